// File: rtl/led_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : led_pwm
//  Description : Eight-channel LED PWM dimmer with prescaler, per-channel duty
//                and frame-based blink gating behind a zero-wait-state bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pwm (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        response,
    input  logic [7:0]  led_in,
    output logic [7:0]  led_out
);

    localparam logic [2:0] c_REG_CTRL     = 3'd0;
    localparam logic [2:0] c_REG_PRESCALE = 3'd1;
    localparam logic [2:0] c_REG_DUTY_LO  = 3'd2;
    localparam logic [2:0] c_REG_DUTY_HI  = 3'd3;
    localparam logic [2:0] c_REG_BLINK    = 3'd4;
    localparam logic [2:0] c_REG_STATUS   = 3'd5;

    logic        r_enable;
    logic [15:0] r_prescale;
    logic [31:0] r_duty_lo;
    logic [31:0] r_duty_hi;
    logic [7:0]  r_blink_mask;
    logic [15:0] r_half_period;

    logic [15:0] r_pre_cnt;
    logic [7:0]  r_pwm_cnt;
    logic [15:0] r_blink_cnt;
    logic        r_blink_phase;
    logic [7:0]  r_led_out;

    logic [2:0]  w_sel;
    logic        w_wr_prescale;
    logic        w_wr_blink;
    logic        w_tick;
    logic        w_frame_end;
    logic [15:0] w_half_m1;
    logic [63:0] w_duty_all;
    logic [7:0]  w_on;
    logic        w_unused;

    assign w_sel         = address[4:2];
    assign w_wr_prescale = write & (w_sel == c_REG_PRESCALE);
    assign w_wr_blink    = write & (w_sel == c_REG_BLINK);
    assign w_unused      = &{1'b0, address[31:5], address[1:0]};

    assign response = read | write;

    always_comb begin
        read_data = 32'h0;
        if (read) begin
            case (w_sel)
                c_REG_CTRL:     read_data = {31'h0, r_enable};
                c_REG_PRESCALE: read_data = {16'h0, r_prescale};
                c_REG_DUTY_LO:  read_data = r_duty_lo;
                c_REG_DUTY_HI:  read_data = r_duty_hi;
                c_REG_BLINK:    read_data = {r_half_period, 8'h0, r_blink_mask};
                c_REG_STATUS:   read_data = {16'h0, r_pwm_cnt, 7'h0, r_blink_phase};
                default:        read_data = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable      <= 1'b0;
            r_prescale    <= 16'h0;
            r_duty_lo     <= 32'h0;
            r_duty_hi     <= 32'h0;
            r_blink_mask  <= 8'h0;
            r_half_period <= 16'h0;
        end else if (write) begin
            case (w_sel)
                c_REG_CTRL:     r_enable   <= write_data[0];
                c_REG_PRESCALE: r_prescale <= write_data[15:0];
                c_REG_DUTY_LO:  r_duty_lo  <= write_data;
                c_REG_DUTY_HI:  r_duty_hi  <= write_data;
                c_REG_BLINK: begin
                    r_blink_mask  <= write_data[7:0];
                    r_half_period <= write_data[31:16];
                end
                default: ;
            endcase
        end
    end

    assign w_tick      = r_enable & (r_pre_cnt == r_prescale);
    assign w_frame_end = w_tick & (r_pwm_cnt == 8'hFF);
    assign w_half_m1   = r_half_period - 16'd1;

    // Disabled state parks every counter so enabling always starts a clean frame.
    always_ff @(posedge clk) begin
        if (reset || !r_enable) begin
            r_pre_cnt     <= 16'h0;
            r_pwm_cnt     <= 8'h0;
            r_blink_cnt   <= 16'h0;
            r_blink_phase <= 1'b1;
        end else begin
            if (w_wr_prescale || w_tick) begin
                r_pre_cnt <= 16'h0;
            end else begin
                r_pre_cnt <= r_pre_cnt + 16'd1;
            end

            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
            end

            if (w_wr_blink || (r_half_period == 16'h0)) begin
                r_blink_cnt   <= 16'h0;
                r_blink_phase <= 1'b1;
            end else if (w_frame_end) begin
                if (r_blink_cnt == w_half_m1) begin
                    r_blink_cnt   <= 16'h0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 16'd1;
                end
            end
        end
    end

    assign w_duty_all = {r_duty_hi, r_duty_lo};

    for (genvar i = 0; i < 8; i++) begin : g_ch
        assign w_on[i] = r_enable & ~led_in[i]
                       & (w_duty_all[8*i +: 8] > r_pwm_cnt)
                       & (~r_blink_mask[i] | r_blink_phase);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led_out <= 8'hFF;
        end else begin
            r_led_out <= ~w_on;
        end
    end

    assign led_out = r_led_out;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pwm
//  Description : Scoreboard bench for led_pwm; stimulus queues expectations,
//                a negedge monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pwm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic [31:0] read_data;
    logic        response;
    logic [7:0]  led_in = 8'hFF;
    logic [7:0]  led_out;

    led_pwm dut (
        .clk        (clk),
        .reset      (reset),
        .read       (read),
        .write      (write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .response   (response),
        .led_in     (led_in),
        .led_out    (led_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        string       name;
        int          ch;
        int          exp_low;
        logic [7:0]  quiet;
    } win_t;

    exp_t rd_q[$];
    exp_t led_q[$];
    win_t win_q[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    logic led_chk = 1'b0;
    logic win_on  = 1'b0;
    logic win_end = 1'b0;
    int   low_cnt[8] = '{default: 0};

    logic [31:0] st_exp[5] = '{32'h101, 32'h101, 32'h101, 32'h101, 32'h201};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        win_t w;
        int   viol;
        if (read || write) chk("response", {31'h0, response}, 32'h1);
        if (write && !read) chk("read_data_idle", read_data, 32'h0);
        if (read) begin
            if (rd_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rd_unexpected: read with no expectation queued");
            end else begin
                e = rd_q.pop_front();
                chk(e.name, read_data, e.val);
            end
        end
        if (led_chk) begin
            if (led_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL led_unexpected: led check with no expectation queued");
            end else begin
                e = led_q.pop_front();
                chk(e.name, {24'h0, led_out}, e.val);
            end
        end
        if (win_on) begin
            for (int i = 0; i < 8; i++) if (!led_out[i]) low_cnt[i]++;
            if (win_end) begin
                if (win_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL win_unexpected: window end with no expectation queued");
                end else begin
                    w = win_q.pop_front();
                    chk({w.name, "_low"}, low_cnt[w.ch], w.exp_low);
                    viol = 0;
                    for (int i = 0; i < 8; i++) if (w.quiet[i]) viol += low_cnt[i];
                    chk({w.name, "_quiet"}, viol, 32'h0);
                end
                for (int i = 0; i < 8; i++) low_cnt[i] = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] sel, input logic [31:0] d);
        address    = {27'h0, sel, 2'b00};
        write_data = d;
        write      = 1'b1;
        @(posedge clk);
        #1;
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        exp_t e;
        e.name = name;
        e.val  = exp;
        rd_q.push_back(e);
        address = addr;
        read    = 1'b1;
        @(posedge clk);
        #1;
        read = 1'b0;
    endtask

    task automatic led_check(input logic [7:0] exp, input string name);
        exp_t e;
        e.name = name;
        e.val  = {24'h0, exp};
        led_q.push_back(e);
        led_chk = 1'b1;
        @(posedge clk);
        #1;
        led_chk = 1'b0;
    endtask

    // Samples led_out on n consecutive cycles starting with the current one.
    task automatic window(input string name, input int ch, input int exp_low,
                          input logic [7:0] quiet, input int n);
        win_t w;
        w.name    = name;
        w.ch      = ch;
        w.exp_low = exp_low;
        w.quiet   = quiet;
        win_q.push_back(w);
        win_on = 1'b1;
        repeat (n - 1) begin
            @(posedge clk);
            #1;
        end
        win_end = 1'b1;
        @(posedge clk);
        #1;
        win_end = 1'b0;
        win_on  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state: all registers zero, STATUS shows blink_phase = 1.
        for (int i = 0; i < 8; i++)
            bus_read(32'(i * 4), (i == 5) ? 32'h1 : 32'h0, $sformatf("rst_off%02h", i * 4));
        bus_read(32'hFFFF_FF14, 32'h1, "status_hi_addr");
        led_check(8'hFF, "led_after_reset");

        // Quarter duty, prescale 0: ch0 low 64 of every 256 cycles.
        bus_write(3'd1, 32'h0);
        bus_write(3'd2, 32'h0000_0040);
        led_in = 8'hFE;
        bus_write(3'd0, 32'h1);
        idle(1);
        window("duty64_a", 0, 64, 8'hFE, 256);
        window("duty64_b", 0, 64, 8'hFE, 256);

        // Full duty on ch0, zero on ch1, all requests on.
        led_in = 8'h00;
        bus_write(3'd2, 32'h0000_00FF);
        idle(1);
        window("duty255", 0, 255, 8'hFE, 256);

        // Prescale 3 with 2-frame blink half-period on ch0.
        bus_write(3'd0, 32'h0);
        bus_write(3'd1, 32'h3);
        bus_write(3'd2, 32'h0000_00FF);
        bus_write(3'd4, 32'h0002_0001);
        led_in = 8'hFE;
        led_check(8'hFF, "led_disabled");
        bus_write(3'd0, 32'h1);
        idle(1);
        window("blink_on", 0, 2040, 8'hFE, 2048);
        window("blink_off", 0, 0, 8'hFE, 2048);
        bus_read(32'h14, 32'h1, "status_k4097");
        idle(2);
        for (int i = 0; i < 5; i++)
            bus_read(32'h14, st_exp[i], $sformatf("status_k%0d", 4100 + i));

        // Reset mid-frame beats a simultaneous CTRL write.
        reset      = 1'b1;
        address    = 32'h0;
        write_data = 32'h1;
        write      = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        write = 1'b0;
        e.name = "led_after_midrst";
        e.val  = 32'hFF;
        led_q.push_back(e);
        led_chk = 1'b1;
        bus_read(32'h0, 32'h0, "ctrl_after_midrst");
        led_chk = 1'b0;
        bus_read(32'h14, 32'h1, "status_after_midrst");

        // Read and write to the same register in one cycle returns the old value.
        bus_write(3'd3, 32'h1122_3344);
        e.name = "duty_hi_old";
        e.val  = 32'h1122_3344;
        rd_q.push_back(e);
        address    = 32'hC;
        write_data = 32'hAABB_CCDD;
        read       = 1'b1;
        write      = 1'b1;
        @(posedge clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
        bus_read(32'hC, 32'hAABB_CCDD, "duty_hi_new");

        idle(2);
        if (rd_q.size() != 0 || led_q.size() != 0 || win_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d/%0d/%0d entries left, expected 0",
                     rd_q.size(), led_q.size(), win_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_pwm.md
LED_PWM -- requirements
Module: led_pwm

Interface
REQ-001 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit, synchronous active-high reset sampled on rising clk.
REQ-003 SHALL have port read, input, 1 bit, bus read strobe.
REQ-004 SHALL have port write, input, 1 bit, bus write strobe.
REQ-005 SHALL have port address, input, 32 bits; only address[4:2] decoded, other bits ignored (upstream decoder selects block).
REQ-006 SHALL have port write_data, input, 32 bits, bus write word.
REQ-007 SHALL have port read_data, output, 32 bits, register read word.
REQ-008 SHALL have port response, output, 1 bit, bus acknowledge.
REQ-009 SHALL have port led_in, input, 8 bits, active-low LED pattern from the LED register stage (0 = LED requested on).
REQ-010 SHALL have port led_out, output, 8 bits, active-low registered drive to the board LED pins.

Function
REQ-011 SHALL drive response = read | write combinationally, same cycle, no wait states.
REQ-012 SHALL drive read_data combinationally from the selected register when read = 1, else 32'h0; unmapped offsets read 0.
REQ-013 SHALL decode register map by address[4:2]: 0 CTRL (bit0 enable), 1 PRESCALE [15:0], 2 DUTY_LO (duty0..3, byte i = channel i), 3 DUTY_HI (duty4..7), 4 BLINK (bits 7:0 blink mask, bits 31:16 half-period in PWM frames), 5 STATUS read-only (bit0 blink_phase, bits 15:8 pwm_cnt); unused bits read 0.
REQ-014 SHALL update the addressed register on the clock edge where write = 1; writes to STATUS or unmapped offsets ignored.
REQ-015 SHALL return the pre-write value when read and write hit the same register in the same cycle.
REQ-016 SHALL run a 16-bit prescaler pre_cnt counting 0..PRESCALE; tick asserted in the cycle pre_cnt == PRESCALE, pre_cnt then returns to 0; PRESCALE = 0 gives tick every cycle.
REQ-017 SHALL clear pre_cnt to 0 on any write to PRESCALE.
REQ-018 SHALL increment 8-bit pwm_cnt on each tick, wrapping 255 -> 0; a frame ends on a tick with pwm_cnt == 255.
REQ-019 SHALL run a 16-bit blink_cnt incremented at each frame end; when blink_cnt reaches half-period - 1 at frame end, blink_cnt clears and blink_phase toggles.
REQ-020 SHALL hold blink_phase = 1 and blink_cnt = 0 while half-period = 0; a write to BLINK clears blink_cnt and sets blink_phase = 1.
REQ-021 SHALL compute channel i on = enable & ~led_in[i] & (duty_i > pwm_cnt) & (~mask[i] | blink_phase); duty 0 never on, duty 255 on 255 of 256 counts.
REQ-022 SHALL register led_out[i] = ~on[i], so led_out reflects state one cycle after inputs/counters.
REQ-023 SHALL, while enable = 0, hold pre_cnt, pwm_cnt, blink_cnt at 0, blink_phase at 1, and led_out at 8'hFF.
REQ-024 SHALL use duty/mask/period values written in cycle N for the led_out computed in cycle N+1 (no frame-boundary shadowing).

Reset
REQ-025 SHALL, on reset, clear CTRL, PRESCALE, DUTY_LO, DUTY_HI, BLINK, pre_cnt, pwm_cnt, blink_cnt to 0, set blink_phase = 1, led_out = 8'hFF.
REQ-026 SHALL give reset priority over a simultaneous write; reset asserted mid-frame restarts all counters from 0 on the next cycle.
REQ-027 SHALL keep response and read_data purely combinational, unaffected by reset.

Verification
REQ-028 SHALL cover: reset, read offset 0x00..0x14 -> all read 0 except STATUS = 0x1; led_out = 0xFF.
REQ-029 SHALL cover: CTRL=1, PRESCALE=0, DUTY_LO=0x00000040, led_in=0xFE -> led_out[0] low exactly 64 of every 256 cycles, other bits stay 1.
REQ-030 SHALL cover: DUTY_LO=0xFF/0x00 on ch0/ch1, led_in=0x00 -> ch0 high only when pwm_cnt=255, ch1 never low.
REQ-031 SHALL cover: PRESCALE=3, BLINK=0x00020001, duty0=0xFF -> pwm_cnt advances every 4 cycles; ch0 output blanked during alternate 2-frame (2048-cycle) windows.
REQ-032 SHALL cover: simultaneous read+write to DUTY_HI (old 0x11223344, new 0xAABBCCDD) -> read_data = 0x11223344, next read 0xAABBCCDD; response = 1 both cycles.
REQ-033 SHALL cover: reset asserted mid-frame with write=1 to CTRL -> CTRL stays 0, pwm_cnt = 0, led_out = 0xFF next cycle.
